// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: a FETCH/DECODE/execute sequencer with a
// memory handshake, a stall watchdog, a sticky fault and a retired-instruction count.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memReady,
  output logic        memRead,
  output logic        memWrite,
  output logic        iorD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic        regWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  pcSource,
  output logic [3:0]  ALUCtrl,
  output logic [3:0]  state,
  output logic        fault,
  output logic [15:0] instrCount
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t      state_q, state_d, dec_state;
  logic [7:0]  stall_q, stall_d;
  logic [15:0] count_q;
  logic        retire;
  logic        waiting;
  logic        timed_out;
  logic        zero_unused;

  // The zero flag gates the PC write in the datapath; the controller only
  // raises pcWriteCond, so the flag is not consumed here.
  assign zero_unused = zero;

  assign state      = state_q;
  assign instrCount = count_q;
  assign fault      = (state_q == HALT);

  // Next-state, output decode, stall tracking and retire detection.
  // While rst_n is low the outputs decode as FETCH with the write strobes masked.
  always_comb begin
    memRead     = 1'b0;
    memWrite    = 1'b0;
    iorD        = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    ALUCtrl     = 4'b0000;
    state_d     = state_q;
    retire      = 1'b0;
    waiting     = 1'b0;
    dec_state   = rst_n ? state_q : FETCH;
    timed_out   = (stall_q >= 8'(TIMEOUT - 1));

    case (dec_state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        ALUCtrl = ALU_ADD;
        waiting = 1'b1;
        if (memReady) begin
          irWrite = rst_n;
          pcWrite = rst_n;
          state_d = DECODE;
        end else if (timed_out) begin
          state_d = HALT;
        end
      end
      DECODE: begin
        aluSrcB = 2'b10;
        ALUCtrl = ALU_ADD;
        case (opcode)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXEC;
          6'b001000:            state_d = ADDIEX;
          6'b000100:            state_d = BRANCH;
          6'b000010:            state_d = JUMP;
          default:              state_d = HALT;
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        ALUCtrl = ALU_ADD;
        state_d = (opcode == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        waiting = 1'b1;
        if (memReady)       state_d = MEMWB;
        else if (timed_out) state_d = HALT;
      end
      MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        waiting  = 1'b1;
        if (memReady) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (timed_out) begin
          state_d = HALT;
        end
      end
      EXEC: begin
        aluSrcA = 1'b1;
        if (funct == 6'b100000) begin
          ALUCtrl = ALU_ADD;
          state_d = RWB;
        end else begin
          state_d = HALT;
        end
      end
      RWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        ALUCtrl = ALU_ADD;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        ALUCtrl     = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = 2'b10;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase

    // Counter is zero outside the wait states, so it is already clear on entry;
    // a completed transfer (memReady high) also clears it.
    stall_d = (waiting && !memReady) ? stall_q + 8'd1 : '0;
  end

  // State, stall counter and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      stall_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      if (retire) count_q <= count_q + 16'd1;
    end
  end

endmodule
